// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response and DataMemory signals of the load/store front end.
interface mem_access_unit_if;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [1:0]  Req_Size;
    logic        Req_Unsigned;
    logic [31:0] Req_Addr;
    logic [31:0] Req_WData;
    logic        Rsp_Valid;
    logic        Rsp_Err;
    logic [31:0] Rsp_RData;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_WriteData;
    logic        Mem_MemWrite;
    logic        Mem_MemRead;
    logic [31:0] Mem_ReadData;
    modport slave (
        input  Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Addr, Req_WData, Mem_ReadData,
        output Req_Ready, Rsp_Valid, Rsp_Err, Rsp_RData, Mem_Address, Mem_WriteData, Mem_MemWrite, Mem_MemRead
    );
    modport master (
        output Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Addr, Req_WData, Mem_ReadData,
        input  Req_Ready, Rsp_Valid, Rsp_Err, Rsp_RData, Mem_Address, Mem_WriteData, Mem_MemWrite, Mem_MemRead
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store front end onto a word-wide DataMemory port;
// sub-word stores are read-modify-write, loads are lane-aligned and extended.
module mem_access_unit #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input logic Clk,
    input logic Rst_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t state, stateNext;
    logic isWrite, isUnsigned;
    logic [1:0] size, offset, laneTop, laneIdx;
    logic [31:0] wData;
    logic [4:0] shift;
    logic [31:0] shifted, loadVal, mask, merged;
    logic accept, misaligned;
    logic readyNext, rspValidNext, rspErrNext, memWriteNext, memReadNext;
    logic [31:0] rspRDataNext, memAddrNext, memWDataNext;

    assign accept = bus.Req_Valid & bus.Req_Ready;
    assign misaligned = (bus.Req_Size == 2'd3) | (bus.Req_Size == 2'd1 & bus.Req_Addr[0])
                      | (bus.Req_Size == 2'd2 & |bus.Req_Addr[1:0]);
    // Lane position inside the word, counted in bytes from bit 0
    assign laneTop = size == 2'd0 ? 2'd0 : size == 2'd1 ? 2'd1 : 2'd3;
    assign laneIdx = BIG_ENDIAN ? 2'd3 - laneTop - offset : offset;
    assign shift = {laneIdx, 3'b000};
    assign shifted = bus.Mem_ReadData >> shift;
    assign loadVal = size == 2'd0 ? {{24{~isUnsigned & shifted[7]}}, shifted[7:0]}
                   : size == 2'd1 ? {{16{~isUnsigned & shifted[15]}}, shifted[15:0]}
                   : bus.Mem_ReadData;
    assign mask = (size == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << shift;
    assign merged = (bus.Mem_ReadData & ~mask) | ((wData << shift) & mask);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            bus.Req_Ready <= 1'b0;
            bus.Rsp_Valid <= 1'b0;
            bus.Rsp_Err <= 1'b0;
            bus.Rsp_RData <= '0;
            bus.Mem_Address <= '0;
            bus.Mem_WriteData <= '0;
            bus.Mem_MemWrite <= 1'b0;
            bus.Mem_MemRead <= 1'b0;
            isWrite <= 1'b0;
            isUnsigned <= 1'b0;
            size <= '0;
            offset <= '0;
            wData <= '0;
        end else begin
            state <= stateNext;
            bus.Req_Ready <= readyNext;
            bus.Rsp_Valid <= rspValidNext;
            bus.Rsp_Err <= rspErrNext;
            bus.Rsp_RData <= rspRDataNext;
            bus.Mem_Address <= memAddrNext;
            bus.Mem_WriteData <= memWDataNext;
            bus.Mem_MemWrite <= memWriteNext;
            bus.Mem_MemRead <= memReadNext;
            if (accept) begin
                isWrite <= bus.Req_Write;
                isUnsigned <= bus.Req_Unsigned;
                size <= bus.Req_Size;
                offset <= bus.Req_Addr[1:0];
                wData <= bus.Req_WData;
            end
        end
    end

    // RESP behaves like IDLE for accepting, which gives back-to-back throughput
    always_comb begin
        stateNext = state;
        readyNext = 1'b0;
        rspValidNext = 1'b0;
        rspErrNext = 1'b0;
        rspRDataNext = '0;
        memAddrNext = '0;
        memWDataNext = '0;
        memWriteNext = 1'b0;
        memReadNext = 1'b0;
        case (state)
            IDLE, RESP: begin
                stateNext = IDLE;
                readyNext = 1'b1;
                if (accept && misaligned) begin
                    stateNext = RESP;
                    rspValidNext = 1'b1;
                    rspErrNext = 1'b1;
                end else if (accept) begin
                    readyNext = 1'b0;
                    memAddrNext = {bus.Req_Addr[31:2], 2'b00};
                    stateNext = bus.Req_Write && bus.Req_Size == 2'd2 ? WRITE : READ;
                    memWriteNext = bus.Req_Write && bus.Req_Size == 2'd2;
                    memReadNext = !(bus.Req_Write && bus.Req_Size == 2'd2);
                    memWDataNext = bus.Req_Write && bus.Req_Size == 2'd2 ? bus.Req_WData : '0;
                end
            end
            READ: begin
                stateNext = isWrite ? WRITE : RESP;
                readyNext = !isWrite;
                rspValidNext = !isWrite;
                rspRDataNext = isWrite ? '0 : loadVal;
                memAddrNext = isWrite ? bus.Mem_Address : '0;
                memWriteNext = isWrite;
                memWDataNext = isWrite ? merged : '0;
            end
            default: begin
                stateNext = RESP;
                readyNext = 1'b1;
                rspValidNext = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store vectors against a word memory model, BIG_ENDIAN=1.
module tb_mem_access_unit;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    int collisions = 0;
    logic [31:0] mem [0:63];
    mem_access_unit_if bus();

    mem_access_unit #(.BIG_ENDIAN(1'b1)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

    always #5 Clk = ~Clk;
    assign bus.Mem_ReadData = mem[bus.Mem_Address[7:2]];
    always @(posedge Clk) if (bus.Mem_MemWrite) mem[bus.Mem_Address[7:2]] <= bus.Mem_WriteData;
    always @(negedge Clk) if (bus.Mem_MemRead && bus.Mem_MemWrite) collisions++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic doReq(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic er,
                         output int lat, output logic touched);
        int n = 0;
        while (!bus.Req_Ready && n < 20) begin
            @(posedge Clk); #1; n++;
        end
        bus.Req_Valid = 1'b1;
        bus.Req_Write = w;
        bus.Req_Size = sz;
        bus.Req_Unsigned = u;
        bus.Req_Addr = a;
        bus.Req_WData = d;
        @(posedge Clk); #1;
        bus.Req_Valid = 1'b0;
        bus.Req_Addr = 32'hFFFF_FFFF;
        bus.Req_WData = 32'h0BAD_0BAD;
        lat = 1;
        touched = bus.Mem_MemRead | bus.Mem_MemWrite;
        while (!bus.Rsp_Valid && lat < 10) begin
            @(posedge Clk); #1; lat++;
            touched |= bus.Mem_MemRead | bus.Mem_MemWrite;
        end
        rd = bus.Rsp_RData;
        er = bus.Rsp_Err;
    endtask

    typedef struct {
        logic w; logic [1:0] sz; logic u; logic [31:0] a; logic [31:0] d;
        logic [31:0] rd; logic er; int lat; string tag;
    } vec_t;

    initial begin
        vec_t v [$];
        logic [31:0] rd, rdList [3];
        logic er, touched;
        int lat, nRsp, cyc [3];
        logic [1:0] szs [3] = '{2'd2, 2'd2, 2'd0};
        logic [31:0] adrs [3] = '{32'h10, 32'h20, 32'h22};
        logic [31:0] exps [3] = '{32'hDEAD_BEEF, 32'h1122_8001, 32'h0000_0080};
        bus.Req_Valid = 1'b0;
        bus.Req_Write = 1'b0;
        bus.Req_Size = 2'd0;
        bus.Req_Unsigned = 1'b0;
        bus.Req_Addr = '0;
        bus.Req_WData = '0;
        #12;
        check("rst ready", {31'd0, bus.Req_Ready}, 0);
        check("rst rspvalid", {31'd0, bus.Rsp_Valid}, 0);
        check("rst memread", {31'd0, bus.Mem_MemRead}, 0);
        check("rst memwrite", {31'd0, bus.Mem_MemWrite}, 0);
        check("rst addr", bus.Mem_Address, 0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        check("ready after rst", {31'd0, bus.Req_Ready}, 1);

        v.push_back('{1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 2, "sw 10"});
        v.push_back('{0, 2'd2, 0, 32'h10, 0, 32'hDEAD_BEEF, 0, 2, "lw 10"});
        v.push_back('{1, 2'd2, 0, 32'h20, 32'h1122_3344, 0, 0, 2, "sw 20"});
        v.push_back('{1, 2'd0, 0, 32'h23, 32'h0000_00AA, 0, 0, 3, "sb 23"});
        v.push_back('{0, 2'd0, 0, 32'h23, 0, 32'hFFFF_FFAA, 0, 2, "lb 23"});
        v.push_back('{0, 2'd0, 1, 32'h23, 0, 32'h0000_00AA, 0, 2, "lbu 23"});
        v.push_back('{0, 2'd0, 1, 32'h20, 0, 32'h0000_0011, 0, 2, "lbu 20"});
        v.push_back('{1, 2'd1, 0, 32'h22, 32'hFFFF_8001, 0, 0, 3, "sh 22"});
        v.push_back('{0, 2'd1, 0, 32'h22, 0, 32'hFFFF_8001, 0, 2, "lh 22"});
        v.push_back('{0, 2'd1, 1, 32'h22, 0, 32'h0000_8001, 0, 2, "lhu 22"});
        v.push_back('{0, 2'd1, 0, 32'h20, 0, 32'h0000_1122, 0, 2, "lh 20"});
        v.push_back('{0, 2'd1, 0, 32'h21, 0, 0, 1, 1, "lh 21 err"});
        v.push_back('{0, 2'd2, 0, 32'h22, 0, 0, 1, 1, "lw 22 err"});
        v.push_back('{0, 2'd3, 0, 32'h20, 0, 0, 1, 1, "size3 err"});
        v.push_back('{1, 2'd1, 0, 32'h21, 32'h0000_7777, 0, 1, 1, "sh 21 err"});
        v.push_back('{1, 2'd2, 0, 32'h26, 32'h0000_7777, 0, 1, 1, "sw 26 err"});
        foreach (v[i]) begin
            doReq(v[i].w, v[i].sz, v[i].u, v[i].a, v[i].d, rd, er, lat, touched);
            check({v[i].tag, " rdata"}, rd, v[i].rd);
            check({v[i].tag, " err"}, {31'd0, er}, {31'd0, v[i].er});
            check({v[i].tag, " latency"}, lat, v[i].lat);
            if (v[i].er) check({v[i].tag, " mem touched"}, {31'd0, touched}, 0);
            if (v[i].tag == "sw 10") check("mem 10", mem[4], 32'hDEAD_BEEF);
            if (v[i].tag == "sb 23") check("mem 20 after sb", mem[8], 32'h1122_33AA);
            if (v[i].tag == "sh 22") check("mem 20 after sh", mem[8], 32'h1122_8001);
        end
        check("mem 20 after errs", mem[8], 32'h1122_8001);

        bus.Req_Valid = 1'b1;
        bus.Req_Write = 1'b1;
        bus.Req_Size = 2'd0;
        bus.Req_Addr = 32'h23;
        bus.Req_WData = 32'h55;
        @(posedge Clk); #1;
        bus.Req_Valid = 1'b0;
        @(posedge Clk); #1;
        check("t5 in write", {31'd0, bus.Mem_MemWrite}, 1);
        #2 Rst_n = 1'b0;
        #1;
        check("t5 memwrite async", {31'd0, bus.Mem_MemWrite}, 0);
        check("t5 ready in rst", {31'd0, bus.Req_Ready}, 0);
        @(posedge Clk); #1;
        check("t5 no rsp", {31'd0, bus.Rsp_Valid}, 0);
        check("t5 mem kept", mem[8], 32'h1122_8001);
        @(negedge Clk) Rst_n = 1'b1;
        @(posedge Clk); #1;
        check("t5 ready after release", {31'd0, bus.Req_Ready}, 1);
        check("t5 no rsp after release", {31'd0, bus.Rsp_Valid}, 0);

        nRsp = 0;
        bus.Req_Valid = 1'b1;
        bus.Req_Write = 1'b0;
        bus.Req_Unsigned = 1'b1;
        bus.Req_Size = szs[0];
        bus.Req_Addr = adrs[0];
        for (int c = 1, k = 0; c <= 20; c++) begin
            logic acc;
            acc = bus.Req_Ready && bus.Req_Valid;
            @(posedge Clk); #1;
            if (acc) begin
                k++;
                bus.Req_Valid = k < 3;
                bus.Req_Size = szs[k % 3];
                bus.Req_Addr = adrs[k % 3];
            end
            if (bus.Rsp_Valid) begin
                if (nRsp < 3) begin
                    rdList[nRsp] = bus.Rsp_RData;
                    cyc[nRsp] = c;
                end
                nRsp++;
            end
        end
        check("t6 count", nRsp, 3);
        for (int i = 0; i < 3; i++) if (nRsp == 3) check($sformatf("t6 data %0d", i), rdList[i], exps[i]);
        if (nRsp == 3) check("t6 gap 01", cyc[1] - cyc[0], 2);
        if (nRsp == 3) check("t6 gap 12", cyc[2] - cyc[1], 2);
        check("read/write overlap", collisions, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
